// File: rtl/jtopl_pkg.sv
// Shared field codes, rhythm bit positions and record layouts for the OPL channel register bank.
package jtopl_pkg;
  localparam logic [1:0] FLD_FNUMLO = 2'd0;
  localparam logic [1:0] FLD_FNUMHI = 2'd1;
  localparam logic [1:0] FLD_FBCON  = 2'd2;

  // positions inside rhy_kon = {BD,SD,TOM,TC,HH}
  localparam int BD  = 4;
  localparam int SD  = 3;
  localparam int TOM = 2;
  localparam int TC  = 1;
  localparam int HH  = 0;

  localparam int CHCSRW = 18;
  localparam int WRRECW = 15;

  typedef struct packed {
    logic       kon;
    logic [2:0] block;
    logic [9:0] fnum;
    logic [2:0] fb;
    logic       con;
  } chreg_t;

  typedef struct packed {
    logic [4:0] ch;
    logic [1:0] fld;
    logic [7:0] din;
  } wr_rec_t;

  function automatic chreg_t apply_wr(input chreg_t r, input wr_rec_t w);
    chreg_t n;
    n = r;
    case (w.fld)
      FLD_FNUMLO: n.fnum[7:0] = w.din;
      FLD_FNUMHI: {n.kon, n.block, n.fnum[9:8]} = w.din[5:0];
      FLD_FBCON:  {n.fb, n.con} = w.din[3:0];
      default:    n = r;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/jtopl_wrfifo.sv
// Synchronous write FIFO; one-cycle write-to-visible, head shown combinationally.
// Caller must not push when full nor pop when empty.
module jtopl_wrfifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // extra pointer bit distinguishes full from empty
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];
endmodule

// File: rtl/jtopl_chreg_bank.sv
// Channel register store with its own slot sequencer; queued host writes land when their channel's modulator slot comes up.
// Optional rhythm key-on override compiled in with JTOPL_RHY_EN.
module jtopl_chreg_bank
  import jtopl_pkg::*;
#(
  parameter int CH     = 9,
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_req,
  output logic       wr_ready,
  input  logic [4:0] wr_ch,
  input  logic [1:0] wr_fld,
  input  logic [7:0] wr_din,
  output logic       busy,
  input  logic       rhy_en,
  input  logic [4:0] rhy_kon,
  output logic       zero,
  output logic [4:0] slot_ch,
  output logic       op,
  output logic       keyon_I,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic [2:0] fb_I,
  output logic       con_I
);
  localparam int SLOTS = 2 * CH;

  logic [5:0] slot;
  logic       cur_op;
  logic [4:0] cur_ch;
  chreg_t     regs [CH];
  chreg_t     cur;
  chreg_t     nxt;
  wr_rec_t    in_rec;
  wr_rec_t    head;
  logic       full, empty, push, pop, wr_valid;
  logic       out_kon, out_con;

  assign cur_op   = (slot >= 6'(CH));
  assign cur_ch   = cur_op ? 5'(slot - 6'(CH)) : slot[4:0];
  assign wr_ready = !full;
  assign busy     = !empty;
  assign wr_valid = (wr_ch < 5'(CH)) && (wr_fld != 2'd3);
  // invalid writes are acknowledged but never queued
  assign push     = wr_req && !full && wr_valid;
  assign in_rec   = wr_rec_t'({wr_ch, wr_fld, wr_din});
  assign pop      = cen && !empty && !cur_op && (head.ch == cur_ch);

  jtopl_wrfifo #(.W(WRRECW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_rec),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    cur = '0;
    for (int i = 0; i < CH; i++) begin
      if (cur_ch == 5'(i)) cur = regs[i];
    end
    nxt = pop ? apply_wr(cur, head) : cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) regs[i] <= '0;
    end else if (pop) begin
      for (int i = 0; i < CH; i++) begin
        if (cur_ch == 5'(i)) regs[i] <= nxt;
      end
    end
  end

`ifdef JTOPL_RHY_EN
  logic       rhy_en_q;
  logic [4:0] rhy_kon_q;

  // sampled once per frame so a whole frame sees one rhythm setting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rhy_en_q  <= 1'b0;
      rhy_kon_q <= '0;
    end else if (cen && slot == 6'd0) begin
      rhy_en_q  <= rhy_en;
      rhy_kon_q <= rhy_kon;
    end
  end

  always_comb begin
    out_kon = nxt.kon;
    out_con = nxt.con;
    if (rhy_en_q) begin
      case (cur_ch)
        5'd6: out_kon = rhy_kon_q[BD];
        5'd7: begin
          out_kon = cur_op ? rhy_kon_q[SD] : rhy_kon_q[HH];
          out_con = 1'b1;
        end
        5'd8: begin
          out_kon = cur_op ? rhy_kon_q[TC] : rhy_kon_q[TOM];
          out_con = 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic rhy_unused;
  assign rhy_unused = ^{rhy_en, rhy_kon};
  assign out_kon    = nxt.kon;
  assign out_con    = nxt.con;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot    <= '0;
      zero    <= 1'b0;
      slot_ch <= '0;
      op      <= 1'b0;
      keyon_I <= 1'b0;
      fnum_I  <= '0;
      block_I <= '0;
      fb_I    <= '0;
      con_I   <= 1'b0;
    end else if (cen) begin
      slot    <= (slot == 6'(SLOTS - 1)) ? 6'd0 : slot + 6'd1;
      zero    <= (slot == 6'd0);
      slot_ch <= cur_ch;
      op      <= cur_op;
      keyon_I <= out_kon;
      fnum_I  <= nxt.fnum;
      block_I <= nxt.block;
      fb_I    <= nxt.fb;
      con_I   <= out_con;
    end
  end
endmodule

// File: tb/tb_jtopl_chreg_bank.sv
// Scoreboard bench for jtopl_chreg_bank: 9-channel instance fully modelled, 18-channel instance spot-checked.
module tb_jtopl_chreg_bank;
  import jtopl_pkg::*;

  localparam int CH = 9;
  localparam int QD = 4;
  localparam int NS = 2 * CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cen, rhy_en;
  logic [4:0] rhy_kon;

  logic       wr_req, wr_ready, busy, zero, op, keyon, con;
  logic [4:0] wr_ch, slot_ch;
  logic [1:0] wr_fld;
  logic [7:0] wr_din;
  logic [9:0] fnum;
  logic [2:0] block, fb;

  logic       b_wr_req, b_wr_ready, b_busy, b_zero, b_op, b_keyon, b_con;
  logic [4:0] b_wr_ch, b_slot_ch;
  logic [1:0] b_wr_fld;
  logic [7:0] b_wr_din;
  logic [9:0] b_fnum;
  logic [2:0] b_block, b_fb;

  jtopl_chreg_bank #(.CH(CH), .QDEPTH(QD)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_fld(wr_fld), .wr_din(wr_din),
    .busy(busy), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .zero(zero), .slot_ch(slot_ch), .op(op),
    .keyon_I(keyon), .fnum_I(fnum), .block_I(block), .fb_I(fb), .con_I(con)
  );

  jtopl_chreg_bank #(.CH(18), .QDEPTH(QD)) u_dut18 (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .wr_req(b_wr_req), .wr_ready(b_wr_ready), .wr_ch(b_wr_ch), .wr_fld(b_wr_fld), .wr_din(b_wr_din),
    .busy(b_busy), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .zero(b_zero), .slot_ch(b_slot_ch), .op(b_op),
    .keyon_I(b_keyon), .fnum_I(b_fnum), .block_I(b_block), .fb_I(b_fb), .con_I(b_con)
  );

  typedef struct packed {
    logic       zero;
    logic [4:0] ch;
    logic       op;
    chreg_t     r;
  } exp_t;

  int      vectors = 0;
  int      miscompares = 0;
  chreg_t  m_regs [CH];
  wr_rec_t m_q [$];
  exp_t    sb [$];
  int      m_slot;
  logic    m_ren;
  logic [4:0] m_rkon;
  wr_rec_t pend;
  logic    pend_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH; i++) m_regs[i] = '0;
    m_q.delete();
    sb.delete();
    m_slot   = 0;
    m_ren    = 1'b0;
    m_rkon   = '0;
    pend_vld = 1'b0;
  endtask

  // one clock; when cen is set the expected output record is queued and checked after the edge
  task automatic tick(input logic cen_v);
    exp_t    e;
    chreg_t  r;
    wr_rec_t h;
    int      c;
    logic    o, acc;
    cen    = cen_v;
    wr_req = pend_vld;
    wr_ch  = pend.ch;
    wr_fld = pend.fld;
    wr_din = pend.din;
    #1;
    check("wr_ready", wr_ready, m_q.size() < QD);
    check("busy", busy, m_q.size() != 0);
    acc = pend_vld && (m_q.size() < QD);
    if (cen_v) begin
      o = (m_slot >= CH);
      c = o ? m_slot - CH : m_slot;
      if (m_slot == 0) begin
        m_ren  = rhy_en;
        m_rkon = rhy_kon;
      end
      if (!o && m_q.size() != 0 && m_q[0].ch == 5'(c)) begin
        h = m_q.pop_front();
        r = m_regs[c];
        if (h.fld == 2'd0) r.fnum[7:0] = h.din;
        else if (h.fld == 2'd1) begin
          r.kon = h.din[5];
          r.block = h.din[4:2];
          r.fnum[9:8] = h.din[1:0];
        end else if (h.fld == 2'd2) begin
          r.fb = h.din[3:1];
          r.con = h.din[0];
        end
        m_regs[c] = r;
      end
      r = m_regs[c];
`ifdef JTOPL_RHY_EN
      if (m_ren && c == 6) r.kon = m_rkon[4];
      if (m_ren && c == 7) begin r.kon = o ? m_rkon[3] : m_rkon[0]; r.con = 1'b1; end
      if (m_ren && c == 8) begin r.kon = o ? m_rkon[1] : m_rkon[2]; r.con = 1'b1; end
`endif
      e.zero = (m_slot == 0);
      e.ch   = 5'(c);
      e.op   = o;
      e.r    = r;
      sb.push_back(e);
      m_slot = (m_slot + 1) % NS;
    end
    if (acc) begin
      if (pend.ch < CH && pend.fld != 2'd3) m_q.push_back(pend);
      pend_vld = 1'b0;
    end
    @(negedge clk);
    if (cen_v) begin
      e = sb.pop_front();
      check("zero", zero, e.zero);
      check("slot_ch", slot_ch, e.ch);
      check("op", op, e.op);
      check("keyon", keyon, e.r.kon);
      check("fnum", fnum, e.r.fnum);
      check("block", block, e.r.block);
      check("fb", fb, e.r.fb);
      check("con", con, e.r.con);
    end
  endtask

  task automatic wr(input int ch, input int fld, input int din);
    pend.ch  = 5'(ch);
    pend.fld = 2'(fld);
    pend.din = 8'(din);
    pend_vld = 1'b1;
    for (int n = 0; n < 4 && pend_vld; n++) tick(1'b0);
    if (pend_vld) begin
      check("wr_accept", wr_ready, 1);
      pend_vld = 1'b0;
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (m_q.size() != 0 && n < bound) begin
      tick(1'b1);
      n++;
    end
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cen = 1'b0; wr_req = 1'b0; b_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    check("rst_zero", zero, 0);
    check("rst_slot_ch", slot_ch, 0);
    check("rst_op", op, 0);
    check("rst_keyon", keyon, 0);
    check("rst_fnum", fnum, 0);
    check("rst_block", block, 0);
    check("rst_fb", fb, 0);
    check("rst_con", con, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic hit;
    rst_n = 1'b0; cen = 1'b0; rhy_en = 1'b0; rhy_kon = '0;
    wr_req = 1'b0; wr_ch = '0; wr_fld = '0; wr_din = '0;
    b_wr_req = 1'b0; b_wr_ch = '0; b_wr_fld = '0; b_wr_din = '0;
    pend = '0; pend_vld = 1'b0;
    @(negedge clk);
    do_reset();

    // idle frames: zero every 18 cen, op high from slot 9
    repeat (2 * NS) tick(1'b1);

    // ch3 fnum lo/hi, then ch2 fbcon
    wr(3, 0, 'hA5);
    wr(3, 1, 'h2E);
    drain(3 * NS);
    repeat (NS) tick(1'b1);
    wr(2, 2, 'h0B);
    drain(2 * NS);

    // fill the queue with no cen, fifth write held until a pop
    for (int i = 0; i < 4; i++) wr(0, 0, 'h11 + i);
    pend.ch = 5'd0; pend.fld = 2'd0; pend.din = 8'h15; pend_vld = 1'b1;
    tick(1'b0);
    tick(1'b0);
    for (int n = 0; n < NS + 2 && pend_vld; n++) tick(1'b1);
    if (pend_vld) begin
      check("held_accept", wr_ready, 1);
      pend_vld = 1'b0;
    end
    drain(6 * NS);

    // in-order: ch1 waits behind ch5; invalid writes acknowledged and dropped
    repeat (6) tick(1'b1);
    wr(5, 0, 'h55);
    wr(1, 0, 'h66);
    wr(9, 0, 'hFF);
    wr(2, 3, 'hFF);
    drain(3 * NS);
    repeat (NS) tick(1'b1);

    // reset with writes pending discards them
    wr(4, 0, 'h77);
    wr(4, 1, 'h3F);
    do_reset();
    repeat (NS) tick(1'b1);

    // rhythm override
    wr(6, 1, 'h20);
    wr(8, 1, 'h20);
    drain(2 * NS);
    rhy_en = 1'b1;
    rhy_kon = 5'b10001;
    repeat (3 * NS) tick(1'b1);
    rhy_en = 1'b0;
    rhy_kon = '0;
    repeat (2 * NS) tick(1'b1);

    // 18-channel instance: ch17 fbcon shows on slots 17 and 35 only
    do_reset();
    b_wr_req = 1'b1; b_wr_ch = 5'd17; b_wr_fld = 2'd2; b_wr_din = 8'h0B;
    #1;
    check("b_wr_ready", b_wr_ready, 1);
    @(negedge clk);
    b_wr_req = 1'b0;
    #1;
    check("b_busy", b_busy, 1);
    for (int k = 0; k < 72; k++) begin
      s = k % 36;
      cen = 1'b1;
      @(negedge clk);
      hit = (k >= 17) && ((s % 18) == 17);
      check("b_slot_ch", b_slot_ch, s % 18);
      check("b_op", b_op, s >= 18);
      check("b_zero", b_zero, s == 0);
      check("b_fb", b_fb, hit ? 5 : 0);
      check("b_con", b_con, hit);
      check("b_keyon", b_keyon, 0);
      check("b_fnum", b_fnum, 0);
    end
    cen = 1'b0;
    check("b_busy_end", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
